// File: rtl/stack_ctrl.sv
// stack_ctrl: parametrised LIFO stack with push, pop and replace-top,
// occupancy count, full/empty/almost-full status, one-cycle error pulses
// and sticky error flags with software clear. All outputs are registered.
module stack_ctrl #(
  parameter int WORD_LEN  = 8,
  parameter int WORD_SIZE = 4,
  parameter int AF_LEVEL  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [WORD_LEN-1:0]   w_data,
  input  logic                  err_clr,
  output logic [WORD_LEN-1:0]   r_data,
  output logic [WORD_SIZE:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  of,
  output logic                  uf,
  output logic                  of_sticky,
  output logic                  uf_sticky
);

  localparam int DEPTH = 2 ** WORD_SIZE;

  // Count is one bit wider than the pointer so DEPTH is representable.
  localparam logic [WORD_SIZE:0]   CNT_ZERO  = (WORD_SIZE+1)'(0);
  localparam logic [WORD_SIZE:0]   CNT_ONE   = (WORD_SIZE+1)'(1);
  localparam logic [WORD_SIZE:0]   CNT_TWO   = (WORD_SIZE+1)'(2);
  localparam logic [WORD_SIZE:0]   CNT_DEPTH = (WORD_SIZE+1)'(DEPTH);
  localparam logic [WORD_SIZE:0]   CNT_AF    = (WORD_SIZE+1)'(AF_LEVEL);
  localparam logic [WORD_SIZE-1:0] IDX_ONE   = (WORD_SIZE)'(1);
  localparam logic [WORD_SIZE-1:0] IDX_TWO   = (WORD_SIZE)'(2);
  localparam logic [WORD_LEN-1:0]  DATA_ZERO = {WORD_LEN{1'b0}};

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_OF   = 3'd4,
    OP_UF   = 3'd5
  } op_e;

  // Storage: contents are don't-care after reset, so no reset on the array.
  logic [WORD_LEN-1:0] mem_q [DEPTH];

  logic [WORD_LEN-1:0]  r_data_q, r_data_d;
  logic [WORD_SIZE:0]   count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 almost_full_q, almost_full_d;
  logic                 of_q, of_d;
  logic                 uf_q, uf_d;
  logic                 of_sticky_q, of_sticky_d;
  logic                 uf_sticky_q, uf_sticky_d;

  op_e                  op_s;
  logic                 mem_we_s;
  logic [WORD_SIZE-1:0] mem_addr_s;
  logic [WORD_SIZE-1:0] top_idx_s;
  logic [WORD_SIZE-1:0] below_idx_s;
  logic [WORD_LEN-1:0]  below_data_s;

  // Pointer arithmetic is modulo DEPTH: with count==DEPTH the low bits are 0
  // and top_idx wraps to DEPTH-1, which is exactly the top slot.
  assign top_idx_s    = count_q[WORD_SIZE-1:0] - IDX_ONE;
  assign below_idx_s  = count_q[WORD_SIZE-1:0] - IDX_TWO;
  assign below_data_s = mem_q[below_idx_s];

  // Decode the requested operation against the current registered status.
  always_comb begin
    op_s = OP_IDLE;
    case ({wr, rd})
      2'b10: begin
        if (full_q) begin
          op_s = OP_OF;
        end else begin
          op_s = OP_PUSH;
        end
      end
      2'b01: begin
        if (empty_q) begin
          op_s = OP_UF;
        end else begin
          op_s = OP_POP;
        end
      end
      2'b11: begin
        // Replace on an empty stack degenerates into a plain push.
        if (empty_q) begin
          op_s = OP_PUSH;
        end else begin
          op_s = OP_REPL;
        end
      end
      default: op_s = OP_IDLE;
    endcase
  end

  // Next-state computation for count, top-of-stack, pulses, sticky flags and status.
  always_comb begin
    count_d     = count_q;
    r_data_d    = r_data_q;
    of_d        = 1'b0;
    uf_d        = 1'b0;
    of_sticky_d = err_clr ? 1'b0 : of_sticky_q;
    uf_sticky_d = err_clr ? 1'b0 : uf_sticky_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = count_q[WORD_SIZE-1:0];
    case (op_s)
      OP_PUSH: begin
        mem_we_s   = 1'b1;
        mem_addr_s = count_q[WORD_SIZE-1:0];
        count_d    = count_q + CNT_ONE;
        r_data_d   = w_data;
      end
      OP_POP: begin
        count_d = count_q - CNT_ONE;
        // The entry below the current top becomes visible; nothing left reads as 0.
        if (count_q >= CNT_TWO) begin
          r_data_d = below_data_s;
        end else begin
          r_data_d = DATA_ZERO;
        end
      end
      OP_REPL: begin
        mem_we_s   = 1'b1;
        mem_addr_s = top_idx_s;
        r_data_d   = w_data;
      end
      OP_OF: begin
        of_d        = 1'b1;
        of_sticky_d = 1'b1;
      end
      OP_UF: begin
        uf_d        = 1'b1;
        uf_sticky_d = 1'b1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    empty_d       = (count_d == CNT_ZERO);
    full_d        = (count_d == CNT_DEPTH);
    almost_full_d = (count_d >= CNT_AF);
  end

  // Control and output registers with synchronous reset that overrides any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= CNT_ZERO;
      r_data_q      <= DATA_ZERO;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      of_q          <= 1'b0;
      uf_q          <= 1'b0;
      of_sticky_q   <= 1'b0;
      uf_sticky_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      r_data_q      <= r_data_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      of_q          <= of_d;
      uf_q          <= uf_d;
      of_sticky_q   <= of_sticky_d;
      uf_sticky_q   <= uf_sticky_d;
    end
  end

  // Storage write port; a reset cycle performs no write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[mem_addr_s] <= w_data;
    end
  end

  assign r_data      = r_data_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign of          = of_q;
  assign uf          = uf_q;
  assign of_sticky   = of_sticky_q;
  assign uf_sticky   = uf_sticky_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed scenario tasks plus a randomised run against a
// reference LIFO model for stack_ctrl (WORD_LEN=8, WORD_SIZE=4, AF_LEVEL=14).
module tb_stack_ctrl;

  logic       clk;
  logic       reset;
  logic       rd;
  logic       wr;
  logic [7:0] w_data;
  logic       err_clr;
  logic [7:0] r_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       of;
  logic       uf;
  logic       of_sticky;
  logic       uf_sticky;

  int checks;
  int failures;

  stack_ctrl #(.WORD_LEN(8), .WORD_SIZE(4), .AF_LEVEL(14)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .err_clr(err_clr), .r_data(r_data), .count(count), .empty(empty),
    .full(full), .almost_full(almost_full), .of(of), .uf(uf),
    .of_sticky(of_sticky), .uf_sticky(uf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs for a single rising edge, then sample 1 time unit later.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic c, input logic rs);
    wr = w; rd = r; w_data = d; err_clr = c; reset = rs;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    checks++;
    if ({count, r_data, empty, full, almost_full, of, uf, of_sticky, uf_sticky}
        !== {5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: count=%0d r_data=%h e/f/af=%b%b%b of/uf=%b%b st=%b%b expected 0,00,100,00,00",
               count, r_data, empty, full, almost_full, of, uf, of_sticky, uf_sticky);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h02 + i), 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i + 1) || r_data !== 8'(8'h02 + i) || almost_full !== (i + 1 >= 14)
          || full !== (i + 1 == 16) || empty !== 1'b0 || of !== 1'b0) begin
        failures++;
        $display("FAIL fill[%0d]: count=%0d r_data=%h af=%b full=%b empty=%b of=%b expected count=%0d r_data=%h af=%b full=%b",
                 i, count, r_data, almost_full, full, empty, of, i + 1, 8'(8'h02 + i),
                 (i + 1 >= 14), (i + 1 == 16));
      end
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    checks++;
    if ({of, of_sticky, full, count, r_data} !== {1'b1, 1'b1, 1'b1, 5'd16, 8'h11}) begin
      failures++;
      $display("FAIL overflow: of=%b of_sticky=%b full=%b count=%0d r_data=%h expected 1,1,1,16,11",
               of, of_sticky, full, count, r_data);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({of, of_sticky, count} !== {1'b0, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL of_pulse_end: of=%b of_sticky=%b count=%0d expected 0,1,16", of, of_sticky, count);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++;
      if (count !== 5'(16 - k) || r_data !== ((k < 16) ? 8'(8'h11 - k) : 8'h00)
          || uf !== 1'b0 || empty !== (k == 16) || full !== 1'b0) begin
        failures++;
        $display("FAIL pop_drain[%0d]: count=%0d r_data=%h uf=%b empty=%b expected count=%0d r_data=%h",
                 k, count, r_data, uf, empty, 16 - k, (k < 16) ? 8'(8'h11 - k) : 8'h00);
      end
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({uf, uf_sticky, of_sticky, count, r_data, empty} !== {1'b1, 1'b1, 1'b1, 5'd0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL underflow: uf=%b uf_st=%b of_st=%b count=%0d r_data=%h empty=%b expected 1,1,1,0,00,1",
               uf, uf_sticky, of_sticky, count, r_data, empty);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({uf, of_sticky, uf_sticky} !== 3'b000) begin
      failures++;
      $display("FAIL err_clr: uf=%b of_st=%b uf_st=%b expected 0,0,0", uf, of_sticky, uf_sticky);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({uf, uf_sticky, of_sticky} !== 3'b110) begin
      failures++;
      $display("FAIL err_vs_clr: uf=%b uf_st=%b of_st=%b expected 1,1,0", uf, uf_sticky, of_sticky);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({uf, uf_sticky} !== 2'b00) begin
      failures++;
      $display("FAIL clr_again: uf=%b uf_st=%b expected 0,0", uf, uf_sticky);
    end
  endtask

  task automatic test_replace();
    cyc(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hB7, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, of, uf} !== {5'd2, 8'hB7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL replace: count=%0d r_data=%h of=%b uf=%b expected 2,B7,0,0", count, r_data, of, uf);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({count, r_data} !== {5'd1, 8'hA1}) begin
      failures++;
      $display("FAIL pop_after_replace: count=%0d r_data=%h expected 1,A1", count, r_data);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, empty} !== {5'd0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL pop_to_empty: count=%0d r_data=%h empty=%b expected 0,00,1", count, r_data, empty);
    end
    cyc(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, uf, uf_sticky, empty} !== {5'd1, 8'hC3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL replace_empty: count=%0d r_data=%h uf=%b uf_st=%b empty=%b expected 1,C3,0,0,0",
               count, r_data, uf, uf_sticky, empty);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
    checks++;
    if ({count, r_data, uf_sticky} !== {5'd5, 8'h34, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset: count=%0d r_data=%h uf_st=%b expected 5,34,1", count, r_data, uf_sticky);
    end
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    checks++;
    if ({count, r_data, empty, of_sticky, uf_sticky} !== {5'd0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: count=%0d r_data=%h empty=%b st=%b%b expected 0,00,1,00",
               count, r_data, empty, of_sticky, uf_sticky);
    end
    cyc(1'b1, 1'b0, 8'h09, 1'b0, 1'b0);
    checks++;
    if ({count, r_data} !== {5'd1, 8'h09}) begin
      failures++;
      $display("FAIL push_after_reset: count=%0d r_data=%h expected 1,09", count, r_data);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive underflows hold uf high each cycle.
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({uf, uf_sticky, count} !== {1'b1, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL uf_b2b_1: uf=%b uf_st=%b count=%0d expected 1,1,0", uf, uf_sticky, count);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (uf !== 1'b1) begin
      failures++;
      $display("FAIL uf_b2b_2: uf=%b expected 1", uf);
    end
    // Fill, then replace at full: no overflow, top updated.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hD5, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, of, full} !== {5'd16, 8'hD5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL replace_full: count=%0d r_data=%h of=%b full=%b expected 16,D5,0,1", count, r_data, of, full);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, full, almost_full} !== {5'd15, 8'h4E, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL pop_below_full: count=%0d r_data=%h full=%b af=%b expected 15,4E,0,1",
               count, r_data, full, almost_full);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({count, r_data, almost_full} !== {5'd13, 8'h4C, 1'b0}) begin
      failures++;
      $display("FAIL af_fall: count=%0d r_data=%h af=%b expected 13,4C,0", count, r_data, almost_full);
    end
  endtask

  task automatic test_random();
    logic [7:0] m [16];
    int         cnt;
    logic [7:0] rdat;
    logic       eof, euf, sof, suf;
    logic       w, r, c;
    logic [7:0] d;
    int         bias;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cnt = 0; rdat = 8'h00; sof = 1'b0; suf = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      bias = ((t / 150) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(99) < bias);
      r = ($urandom_range(99) < (100 - bias));
      c = ($urandom_range(99) < 8);
      d = 8'($urandom_range(255));
      eof = 1'b0; euf = 1'b0;
      if (c) begin sof = 1'b0; suf = 1'b0; end
      if (w && !r) begin
        if (cnt == 16) begin eof = 1'b1; sof = 1'b1; end
        else begin m[cnt] = d; cnt++; rdat = d; end
      end else if (!w && r) begin
        if (cnt == 0) begin euf = 1'b1; suf = 1'b1; end
        else begin cnt--; rdat = (cnt > 0) ? m[cnt-1] : 8'h00; end
      end else if (w && r) begin
        if (cnt == 0) begin m[0] = d; cnt = 1; rdat = d; end
        else begin m[cnt-1] = d; rdat = d; end
      end
      cyc(w, r, d, c, 1'b0);
      checks++;
      if ({count, r_data, empty, full, almost_full, of, uf, of_sticky, uf_sticky}
          !== {5'(cnt), rdat, (cnt == 0), (cnt == 16), (cnt >= 14), eof, euf, sof, suf}) begin
        failures++;
        $display("FAIL random[%0d]: count=%0d r_data=%h e/f/af=%b%b%b of/uf=%b%b st=%b%b expected count=%0d r_data=%h e/f/af=%b%b%b of/uf=%b%b st=%b%b",
                 t, count, r_data, empty, full, almost_full, of, uf, of_sticky, uf_sticky,
                 cnt, rdat, (cnt == 0), (cnt == 16), (cnt >= 14), eof, euf, sof, suf);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00; err_clr = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_replace();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
